// File: rtl/neuron_mac_sequencer_pkg.sv
// Fixed-point types and helpers shared by the neuron datapath.
// frac_t is signed Q3.12; unit_t is unsigned Q0.8 covering [0, 1).
package neuron_mac_sequencer_pkg;

  localparam int unsigned FRAC_W  = 16;
  localparam int unsigned FRAC_FB = 12;
  localparam int unsigned UNIT_W  = 8;

  typedef logic signed [FRAC_W-1:0] frac_t;
  typedef logic        [UNIT_W-1:0] unit_t;

  localparam frac_t FRAC_MAX = 16'sh7FFF;
  localparam frac_t FRAC_MIN = 16'sh8000;

  typedef enum logic [1:0] {IDLE, MAC, FINAL, OUT} nms_state_t;

  function automatic frac_t unit_to_frac(input unit_t u);
    return frac_t'({{(FRAC_W-FRAC_FB){1'b0}}, u, {(FRAC_FB-UNIT_W){1'b0}}});
  endfunction

  // Full-precision product, arithmetic shift (truncates toward -inf), then saturate.
  function automatic frac_t frac_mul(input frac_t a, input frac_t b);
    logic signed [2*FRAC_W-1:0] p;
    p = (2*FRAC_W)'(a) * (2*FRAC_W)'(b);
    p = p >>> FRAC_FB;
    if (p > (2*FRAC_W)'(FRAC_MAX)) return FRAC_MAX;
    if (p < (2*FRAC_W)'(FRAC_MIN)) return FRAC_MIN;
    return p[FRAC_W-1:0];
  endfunction

endpackage

// File: rtl/neuron_mac_sequencer.sv
// Single-neuron evaluator: bias + sum(x[i]*w[i]) through one shared multiplier,
// one product per cycle, with optional ReLU and saturation at the end.
module neuron_mac_sequencer
  import neuron_mac_sequencer_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter bit          ACT_RELU = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  unit_t [N-1:0]     x,
  input  frac_t [N-1:0]     w,
  input  frac_t             bias,
  output logic              out_valid,
  input  logic              out_ready,
  output frac_t             out,
  output logic              out_sat,
  output logic              busy
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ACC_W = FRAC_W + $clog2(N) + 1;

  typedef logic signed [ACC_W-1:0] acc_t;

  nms_state_t       state, state_nx;
  logic [IDX_W-1:0] idx;
  acc_t             acc;
  unit_t [N-1:0]    x_r;
  frac_t [N-1:0]    w_r;
  frac_t            bias_r;

  logic  idx_last;
  frac_t prod;
  acc_t  mac_sum;
  acc_t  fin_sum;
  frac_t res;
  logic  res_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = MAC;
      end
      MAC:   if (idx_last) state_nx = FINAL;
      FINAL: state_nx = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    idx_last = (idx == IDX_W'(N-1));
    prod     = frac_mul(unit_to_frac(x_r[idx]), w_r[idx]);
    mac_sum  = acc + acc_t'(prod);
    fin_sum  = acc + acc_t'(bias_r);
    res      = fin_sum[FRAC_W-1:0];
    res_sat  = 1'b0;
    if (fin_sum > acc_t'(FRAC_MAX)) begin
      res     = FRAC_MAX;
      res_sat = 1'b1;
    end else if (fin_sum < acc_t'(FRAC_MIN)) begin
      res     = FRAC_MIN;
      res_sat = 1'b1;
    end
    // ReLU clears the value but keeps the saturation flag of the pre-activation sum.
    if (ACT_RELU && res[FRAC_W-1]) res = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      acc     <= '0;
      x_r     <= '0;
      w_r     <= '0;
      bias_r  <= '0;
      out     <= '0;
      out_sat <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x_r    <= x;
            w_r    <= w;
            bias_r <= bias;
            acc    <= '0;
            idx    <= '0;
          end
        end
        MAC: begin
          acc <= mac_sum;
          idx <= idx_last ? '0 : idx + IDX_W'(1);
        end
        FINAL: begin
          out     <= res;
          out_sat <= res_sat;
        end
        OUT: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed bench for neuron_mac_sequencer: four instances covering N=2/4 and ReLU on/off.
module tb_neuron_mac_sequencer;
  import neuron_mac_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // index: 0 = N2/linear, 1 = N2/relu, 2 = N4/relu, 3 = N4/linear
  logic [3:0]  in_valid;
  logic [3:0]  out_ready;
  wire  [3:0]  in_ready;
  wire  [3:0]  out_valid;
  wire  [3:0]  out_sat;
  wire  [3:0]  busy;
  unit_t [3:0] x_s [4];
  frac_t [3:0] w_s [4];
  frac_t [3:0] bias_s;
  wire frac_t [3:0] out_s;

  int checks = 0;
  int errors = 0;

  neuron_mac_sequencer #(.N(2), .ACT_RELU(1'b0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .x(x_s[0][1:0]), .w(w_s[0][1:0]), .bias(bias_s[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out(out_s[0]),
    .out_sat(out_sat[0]), .busy(busy[0]));

  neuron_mac_sequencer #(.N(2), .ACT_RELU(1'b1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .x(x_s[1][1:0]), .w(w_s[1][1:0]), .bias(bias_s[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out(out_s[1]),
    .out_sat(out_sat[1]), .busy(busy[1]));

  neuron_mac_sequencer #(.N(4), .ACT_RELU(1'b1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .x(x_s[2]), .w(w_s[2]), .bias(bias_s[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out(out_s[2]),
    .out_sat(out_sat[2]), .busy(busy[2]));

  neuron_mac_sequencer #(.N(4), .ACT_RELU(1'b0)) dut_d (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .x(x_s[3]), .w(w_s[3]), .bias(bias_s[3]),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out(out_s[3]),
    .out_sat(out_sat[3]), .busy(busy[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present a job at the negedge, let it be accepted, then scramble the inputs.
  task automatic accept(input int k, input unit_t [3:0] xv, input frac_t [3:0] wv,
                        input frac_t bv, input string tag);
    @(negedge clk);
    in_valid[k] = 1'b1;
    x_s[k]      = xv;
    w_s[k]      = wv;
    bias_s[k]   = bv;
    check({tag, "_in_ready_before"}, in_ready[k], 1);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    x_s[k]      = {4{unit_t'($urandom)}};
    w_s[k]      = {4{frac_t'($urandom)}};
    bias_s[k]   = frac_t'($urandom);
    check({tag, "_busy_after"}, busy[k], 1);
    check({tag, "_in_ready_after"}, in_ready[k], 0);
  endtask

  task automatic wait_out(input int k, output int cyc);
    cyc = 0;
    while (out_valid[k] !== 1'b1 && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic handshake(input int k, input string tag);
    @(negedge clk);
    out_ready[k] = 1'b1;
    check({tag, "_valid_pre_hs"}, out_valid[k], 1);
    @(posedge clk);
    #1;
    out_ready[k] = 1'b0;
    check({tag, "_valid_post_hs"}, out_valid[k], 0);
    check({tag, "_in_ready_post_hs"}, in_ready[k], 1);
    check({tag, "_busy_post_hs"}, busy[k], 0);
  endtask

  task automatic run_job(input int k, input unit_t [3:0] xv, input frac_t [3:0] wv,
                         input frac_t bv, input int lat, input frac_t eo,
                         input logic es, input string tag);
    int cyc;
    accept(k, xv, wv, bv, tag);
    wait_out(k, cyc);
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_out"}, out_s[k], eo);
    check({tag, "_sat"}, out_sat[k], es);
    handshake(k, tag);
  endtask

  initial begin
    unit_t [3:0] xv;
    frac_t [3:0] wv;
    int cyc;
    int acc_at [$];
    logic stray;

    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    bias_s    = '0;
    for (int k = 0; k < 4; k++) begin
      x_s[k] = '0;
      w_s[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 4'hF);
    check("reset_out_valid", out_valid, 4'h0);
    check("reset_busy", busy, 4'h0);
    check("reset_out_sat", out_sat, 4'h0);
    for (int k = 0; k < 4; k++) check("reset_out", out_s[k], 0);
    @(negedge clk);
    rst = 1'b0;

    // 0.5*2.0 + 0.25*(-1.0) + 0.125 = 0.875
    xv = '0; wv = '0;
    xv[0] = 8'd128; xv[1] = 8'd64;
    wv[0] = 16'sd8192; wv[1] = -16'sd4096;
    run_job(0, xv, wv, 16'sd512, 3, 16'sd3584, 1'b0, "t1");

    // -0.5 - 0.5 + 0.25 = -0.75 -> ReLU 0
    xv = '0; wv = '0;
    xv[0] = 8'd128; xv[1] = 8'd128;
    wv[0] = -16'sd4096; wv[1] = -16'sd4096;
    run_job(1, xv, wv, 16'sd1024, 3, 16'sd0, 1'b0, "t2");

    // Positive overflow, then negative overflow on the linear instance
    xv = {4{8'd255}};
    wv = {4{FRAC_MAX}};
    run_job(2, xv, wv, FRAC_MAX, 5, FRAC_MAX, 1'b1, "t3_pos");
    wv = {4{FRAC_MIN}};
    run_job(3, xv, wv, FRAC_MAX, 5, FRAC_MIN, 1'b1, "t3_neg");

    // Reset while dut_c sits in MAC with idx=1
    xv = {4{8'd255}};
    wv = {4{FRAC_MAX}};
    run_job(2, xv, wv, FRAC_MAX, 5, FRAC_MAX, 1'b1, "t5_pre");
    accept(2, xv, wv, FRAC_MAX, "t5_job");
    @(posedge clk);
    #1;
    check("t5_busy_in_mac", busy[2], 1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_busy", busy[2], 0);
    check("t5_rst_out_valid", out_valid[2], 0);
    check("t5_rst_in_ready", in_ready[2], 1);
    check("t5_rst_out", out_s[2], 0);
    check("t5_rst_out_sat", out_sat[2], 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_no_output_after_rst", out_valid[2], 0);
    // 0.5*1 + 0.25*2 + (255/256)*(-1) + 0 + 0.0625 = 272/4096
    xv = '0; wv = '0;
    xv[0] = 8'd128; xv[1] = 8'd64; xv[2] = 8'd255; xv[3] = 8'd0;
    wv[0] = 16'sd4096; wv[1] = 16'sd8192; wv[2] = -16'sd4096; wv[3] = FRAC_MAX;
    run_job(2, xv, wv, 16'sd256, 5, 16'sd272, 1'b0, "t5_post");

    // Backpressure: result held, in_ready low, extra request ignored
    xv = '0; wv = '0;
    xv[0] = 8'd128; xv[1] = 8'd64;
    wv[0] = 16'sd8192; wv[1] = -16'sd4096;
    accept(0, xv, wv, 16'sd512, "t4");
    wait_out(0, cyc);
    check("t4_latency", cyc, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", out_valid[0], 1);
      check("t4_hold_out", out_s[0], 16'sd3584);
      check("t4_hold_sat", out_sat[0], 0);
      check("t4_hold_in_ready", in_ready[0], 0);
      if (i == 1) begin
        in_valid[0] = 1'b1;
        x_s[0]      = {4{8'd255}};
        w_s[0]      = {4{16'sd4096}};
      end
      if (i == 2) in_valid[0] = 1'b0;
    end
    handshake(0, "t4");
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) stray = 1'b1;
    end
    check("t4_ignored_request", stray, 0);

    // Back-to-back jobs with out_ready held high
    @(negedge clk);
    x_s[0]       = xv;
    w_s[0]       = wv;
    bias_s[0]    = 16'sd512;
    in_valid[0]  = 1'b1;
    out_ready[0] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (in_ready[0] === 1'b1) acc_at.push_back(c);
      if (out_valid[0] === 1'b1) check("t6_b2b_out", out_s[0], 16'sd3584);
    end
    in_valid[0] = 1'b0;
    check("t6_accept_count", acc_at.size(), 3);
    if (acc_at.size() >= 3) begin
      check("t6_spacing_1", acc_at[1] - acc_at[0], 5);
      check("t6_spacing_2", acc_at[2] - acc_at[1], 5);
    end
    repeat (8) @(negedge clk);
    out_ready[0] = 1'b0;
    check("t6_drained_busy", busy[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
